// File: rtl/branch_target_predictor.sv
// rtl/branch_target_predictor.sv - direct-mapped BTB with saturating direction counters (optional STATS_EN)
`timescale 1ns/1ps
module branch_target_predictor #(
    parameter int ADDR_W  = 16,
    parameter int ENTRIES = 16,
    parameter int CTR_W   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] fetch_pc,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_target,
    input  logic              res_valid,
    input  logic [ADDR_W-1:0] res_pc,
    input  logic              res_taken,
    input  logic [ADDR_W-1:0] res_target,
    input  logic              res_pred_taken,
    input  logic [ADDR_W-1:0] res_pred_target,
    output logic              mispredict,
    input  logic              flush_all,
    output logic [15:0]       stat_lookups,
    output logic [15:0]       stat_mispredicts
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W - 1;

    localparam logic [CTR_W-1:0] CTR_MAX = {CTR_W{1'b1}};
    localparam logic [CTR_W-1:0] CTR_MIN = {CTR_W{1'b0}};
    localparam logic [CTR_W-1:0] CTR_WNT = {1'b0, {(CTR_W-1){1'b1}}};
    localparam logic [CTR_W-1:0] CTR_WT  = {1'b1, {(CTR_W-1){1'b0}}};

    logic              valid_q [ENTRIES];
    logic              valid_d [ENTRIES];
    logic [TAG_W-1:0]  tag_q   [ENTRIES];
    logic [TAG_W-1:0]  tag_d   [ENTRIES];
    logic [ADDR_W-1:0] tgt_q   [ENTRIES];
    logic [ADDR_W-1:0] tgt_d   [ENTRIES];
    logic [CTR_W-1:0]  ctr_q   [ENTRIES];
    logic [CTR_W-1:0]  ctr_d   [ENTRIES];

    logic [IDX_W-1:0]  f_idx;
    logic [TAG_W-1:0]  f_tag;
    logic [IDX_W-1:0]  r_idx;
    logic [TAG_W-1:0]  r_tag;
    logic              r_hit;
    logic              unused_pc_lsb;

    // Halfword-aligned PCs: bit 0 carries no information for index or tag.
    assign f_idx = fetch_pc[IDX_W:1];
    assign f_tag = fetch_pc[ADDR_W-1:IDX_W+1];
    assign r_idx = res_pc[IDX_W:1];
    assign r_tag = res_pc[ADDR_W-1:IDX_W+1];
    assign unused_pc_lsb = fetch_pc[0] ^ res_pc[0];

    // Zero-latency lookup from the current array contents only.
    assign pred_hit    = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    assign pred_taken  = pred_hit && ctr_q[f_idx][CTR_W-1];
    assign pred_target = pred_hit ? tgt_q[f_idx] : '0;

    assign r_hit = valid_q[r_idx] && (tag_q[r_idx] == r_tag);

    assign mispredict = res_valid && ((res_taken != res_pred_taken) ||
                                      (res_taken && (res_target != res_pred_target)));

    // Next-state for the entry array: flush beats training, training touches one index.
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        tgt_d   = tgt_q;
        ctr_d   = ctr_q;
        if (flush_all) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_d[i] = 1'b0;
            end
        end else if (res_valid) begin
            if (r_hit) begin
                if (res_taken) begin
                    tgt_d[r_idx] = res_target;
                    if (ctr_q[r_idx] != CTR_MAX) begin
                        ctr_d[r_idx] = ctr_q[r_idx] + CTR_W'(1);
                    end
                end else if (ctr_q[r_idx] != CTR_MIN) begin
                    ctr_d[r_idx] = ctr_q[r_idx] - CTR_W'(1);
                end
            end else if (res_taken) begin
                valid_d[r_idx] = 1'b1;
                tag_d[r_idx]   = r_tag;
                tgt_d[r_idx]   = res_target;
                ctr_d[r_idx]   = CTR_WT;
            end
        end
    end

    // Entry array registers; reset leaves every counter weakly not-taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                tgt_q[i]   <= '0;
                ctr_q[i]   <= CTR_WNT;
            end
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            tgt_q   <= tgt_d;
            ctr_q   <= ctr_d;
        end
    end

`ifdef STATS_EN
    logic [15:0] stat_lookups_q;
    logic [15:0] stat_lookups_d;
    logic [15:0] stat_mispredicts_q;
    logic [15:0] stat_mispredicts_d;

    // Saturating event counters; flush_all deliberately leaves them alone.
    always_comb begin
        stat_lookups_d     = stat_lookups_q;
        stat_mispredicts_d = stat_mispredicts_q;
        if (res_valid && (stat_lookups_q != 16'hFFFF)) begin
            stat_lookups_d = stat_lookups_q + 16'd1;
        end
        if (mispredict && (stat_mispredicts_q != 16'hFFFF)) begin
            stat_mispredicts_d = stat_mispredicts_q + 16'd1;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_lookups_q     <= 16'h0000;
            stat_mispredicts_q <= 16'h0000;
        end else begin
            stat_lookups_q     <= stat_lookups_d;
            stat_mispredicts_q <= stat_mispredicts_d;
        end
    end

    assign stat_lookups     = stat_lookups_q;
    assign stat_mispredicts = stat_mispredicts_q;
`else
    assign stat_lookups     = 16'h0000;
    assign stat_mispredicts = 16'h0000;
`endif

endmodule

// File: tb/tb_branch_target_predictor.sv
// tb/tb_branch_target_predictor.sv - randomized and directed check of branch_target_predictor against a reference model
`timescale 1ns/1ps
module tb_branch_target_predictor;

    localparam int ENT = 16;
    localparam int IDXB = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] fetch_pc;
    logic        pred_hit;
    logic        pred_taken;
    logic [15:0] pred_target;
    logic        res_valid;
    logic [15:0] res_pc;
    logic        res_taken;
    logic [15:0] res_target;
    logic        res_pred_taken;
    logic [15:0] res_pred_target;
    logic        mispredict;
    logic        flush_all;
    logic [15:0] stat_lookups;
    logic [15:0] stat_mispredicts;

    int n_checks = 0;
    int n_errors = 0;

    bit m_valid [ENT];
    int m_tag   [ENT];
    int m_tgt   [ENT];
    int m_ctr   [ENT];
    int m_lk;
    int m_mp;

    branch_target_predictor #(.ADDR_W(16), .ENTRIES(ENT), .CTR_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .fetch_pc(fetch_pc),
        .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
        .res_valid(res_valid), .res_pc(res_pc), .res_taken(res_taken),
        .res_target(res_target), .res_pred_taken(res_pred_taken),
        .res_pred_target(res_pred_target), .mispredict(mispredict),
        .flush_all(flush_all), .stat_lookups(stat_lookups),
        .stat_mispredicts(stat_mispredicts)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int idx_of(input int pc);
        return (pc / 2) % ENT;
    endfunction

    function automatic int tag_of(input int pc);
        return pc / (2 * ENT);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ENT; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
        end
        m_lk = 0; m_mp = 0;
    endtask

    function automatic bit model_mp();
        return res_valid && ((res_taken != res_pred_taken) ||
                             (res_taken && res_target != res_pred_target));
    endfunction

    task automatic model_step();
        int i, t;
        bit mp;
        mp = model_mp();
        i = idx_of(int'(res_pc));
        t = tag_of(int'(res_pc));
`ifdef STATS_EN
        if (res_valid && m_lk < 65535) m_lk++;
        if (mp && m_mp < 65535) m_mp++;
`endif
        if (flush_all) begin
            for (int k = 0; k < ENT; k++) m_valid[k] = 0;
        end else if (res_valid) begin
            if (m_valid[i] && m_tag[i] == t) begin
                if (res_taken) begin
                    m_ctr[i] = (m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1;
                    m_tgt[i] = int'(res_target);
                end else begin
                    m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
                end
            end else if (res_taken) begin
                m_valid[i] = 1; m_tag[i] = t; m_tgt[i] = int'(res_target); m_ctr[i] = 2;
            end
        end
    endtask

    // One clock: model-compare outputs at the falling edge, optional fixed expectations, then advance.
    task automatic cycle(input int eh = -1, input int et = -1, input int etg = -1, input int emp = -1);
        int i, t;
        bit hit;
        @(negedge clk);
        i = idx_of(int'(fetch_pc));
        t = tag_of(int'(fetch_pc));
        hit = m_valid[i] && m_tag[i] == t;
        check("hit", 32'(pred_hit), 32'(hit));
        check("taken", 32'(pred_taken), 32'(hit && m_ctr[i] >= 2));
        check("target", 32'(pred_target), hit ? 32'(m_tgt[i]) : 32'd0);
        check("mispredict", 32'(mispredict), 32'(model_mp()));
        check("stat_lk", 32'(stat_lookups), 32'(m_lk));
        check("stat_mp", 32'(stat_mispredicts), 32'(m_mp));
        if (eh >= 0)  check("fixed_hit", 32'(pred_hit), 32'(eh));
        if (et >= 0)  check("fixed_taken", 32'(pred_taken), 32'(et));
        if (etg >= 0) check("fixed_target", 32'(pred_target), 32'(etg));
        if (emp >= 0) check("fixed_mispredict", 32'(mispredict), 32'(emp));
        @(posedge clk);
        model_step();
        #1;
        res_valid = 1'b0;
        flush_all = 1'b0;
    endtask

    task automatic look(input int pc, input int eh, input int et, input int etg);
        fetch_pc = 16'(pc);
        res_valid = 1'b0;
        flush_all = 1'b0;
        cycle(eh, et, etg, 0);
    endtask

    task automatic resolve(input int pc, input bit tk, input int tg, input bit ptk, input int ptg,
                           input bit fl = 1'b0, input int emp = -1);
        res_valid = 1'b1;
        res_pc = 16'(pc);
        res_taken = tk;
        res_target = 16'(tg);
        res_pred_taken = ptk;
        res_pred_target = 16'(ptg);
        flush_all = fl;
        cycle(-1, -1, -1, emp);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        res_valid = 1'b0;
        flush_all = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    int exp_nt [3] = '{0, 0, 0};
    int exp_t  [4] = '{0, 1, 1, 1};

    initial begin
        fetch_pc = 16'h0; res_pc = 16'h0; res_taken = 1'b0; res_target = 16'h0;
        res_pred_taken = 1'b0; res_pred_target = 16'h0;
        do_reset();

        look(16'h0010, 0, 0, 0);

        // Reset asserted while an update is pending drops it.
        res_valid = 1'b1; res_pc = 16'h0024; res_taken = 1'b1; res_target = 16'h0040;
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1;
        res_valid = 1'b0;
        rst_n = 1'b1;
        model_reset();
        look(16'h0024, 0, 0, 0);

        // Allocation, with a same-cycle lookup still seeing the old contents.
        fetch_pc = 16'h0024;
        res_valid = 1'b1; res_pc = 16'h0024; res_taken = 1'b1; res_target = 16'h0040;
        res_pred_taken = 1'b0; res_pred_target = 16'h0;
        cycle(0, 0, 0, 1);
        look(16'h0024, 1, 1, 16'h0040);

        for (int k = 0; k < 3; k++) begin
            resolve(16'h0024, 1'b0, 0, 1'b0, 0);
            look(16'h0024, 1, exp_nt[k], 16'h0040);
        end
        for (int k = 0; k < 4; k++) begin
            resolve(16'h0024, 1'b1, 16'h0040, 1'b1, 16'h0040);
            look(16'h0024, 1, exp_t[k], 16'h0040);
        end

        look(16'h0044, 0, 0, 0);
        resolve(16'h0044, 1'b1, 16'h0100, 1'b0, 0);
        look(16'h0044, 1, 1, 16'h0100);
        look(16'h0024, 0, 0, 0);
        resolve(16'h0066, 1'b0, 0, 1'b0, 0);
        look(16'h0066, 0, 0, 0);

        resolve(16'h0060, 1'b1, 16'h0200, 1'b0, 0, 1'b1);
        look(16'h0044, 0, 0, 0);
        look(16'h0060, 0, 0, 0);

        do_reset();
        resolve(16'h0024, 1'b1, 16'h0040, 1'b1, 16'h0042, 1'b0, 1);
        resolve(16'h0030, 1'b0, 0, 1'b1, 0, 1'b0, 1);
        resolve(16'h0024, 1'b1, 16'h0040, 1'b1, 16'h0040, 1'b0, 0);
`ifdef STATS_EN
        check("t6_lookups", 32'(stat_lookups), 32'd3);
        check("t6_mispredicts", 32'(stat_mispredicts), 32'd2);
`else
        check("t6_lookups", 32'(stat_lookups), 32'd0);
        check("t6_mispredicts", 32'(stat_mispredicts), 32'd0);
`endif

        // Random traffic over a small PC pool so hits, aliases and saturation all occur.
        for (int n = 0; n < 600; n++) begin
            fetch_pc = 16'(($urandom_range(0, 3) << 5) | ($urandom_range(0, 15) << 1) | $urandom_range(0, 1));
            res_valid = 1'($urandom_range(0, 3) != 0);
            res_pc = 16'(($urandom_range(0, 3) << 5) | ($urandom_range(0, 15) << 1) | $urandom_range(0, 1));
            res_taken = 1'($urandom_range(0, 1));
            res_target = 16'($urandom);
            res_pred_taken = 1'($urandom_range(0, 1));
            res_pred_target = ($urandom_range(0, 1) == 1) ? res_target : 16'($urandom);
            flush_all = 1'($urandom_range(0, 29) == 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
